// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------
// alu_arbiter_if : requester / ALU signal bundle for alu_arbiter. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

`ifndef DSIZE
`define DSIZE 16
`endif

interface alu_arbiter_if #(
  parameter int DSIZE = `DSIZE
);
  logic             req0;
  logic             req1;
  logic [2:0]       op0;
  logic [2:0]       op1;
  logic [DSIZE-1:0] a0;
  logic [DSIZE-1:0] b0;
  logic [DSIZE-1:0] a1;
  logic [DSIZE-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             rdy0;
  logic             rdy1;
  logic [DSIZE-1:0] res;
  logic             zero;
  logic             busy;
  logic [DSIZE-1:0] alu_a;
  logic [DSIZE-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [DSIZE-1:0] alu_out;
  logic             alu_zero;

  // The arbiter side.
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_zero,
    output gnt0, gnt1, rdy0, rdy1, res, zero, busy, alu_a, alu_b, alu_op
  );

  // The environment side: both requesters plus the shared ALU.
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_zero,
    input  gnt0, gnt1, rdy0, rdy1, res, zero, busy, alu_a, alu_b, alu_op
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------
// alu_arbiter : two-requester arbiter/sequencer for one shared ALU.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0). Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

`ifndef DSIZE
`define DSIZE 16
`endif

module alu_arbiter #(
  parameter int DSIZE = `DSIZE
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e           state_q,    state_d;
  logic             last_win_q, last_win_d;
  logic             win_q,      win_d;
  logic             gnt0_q,     gnt0_d;
  logic             gnt1_q,     gnt1_d;
  logic             rdy0_q,     rdy0_d;
  logic             rdy1_q,     rdy1_d;
  logic [DSIZE-1:0] res_q,      res_d;
  logic             zero_q,     zero_d;
  logic [DSIZE-1:0] alu_a_q,    alu_a_d;
  logic [DSIZE-1:0] alu_b_q,    alu_b_d;
  logic [2:0]       alu_op_q,   alu_op_d;
  logic             pick;

  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    win_d      = win_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rdy0_d     = 1'b0;
    rdy1_d     = 1'b0;
    res_d      = res_q;
    zero_d     = zero_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    pick       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          pick = !bus.req0;
`else
          // On a tie the requester that did not win last time goes first.
          pick = (bus.req0 && bus.req1) ? !last_win_q : bus.req1;
`endif
          win_d      = pick;
          last_win_d = pick;
          gnt0_d     = !pick;
          gnt1_d     = pick;
          alu_op_d   = pick ? bus.op1 : bus.op0;
          alu_a_d    = pick ? bus.a1  : bus.a0;
          alu_b_d    = pick ? bus.b1  : bus.b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_out;
        zero_d  = bus.alu_zero;
        rdy0_d  = !win_q;
        rdy1_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_win_q <= 1'b1;
      win_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rdy0_q     <= 1'b0;
      rdy1_q     <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      win_q      <= win_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rdy0_q     <= rdy0_d;
      rdy1_q     <= rdy1_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.rdy0   = rdy0_q;
  assign bus.rdy1   = rdy1_q;
  assign bus.res    = res_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = (state_q == EXEC);
  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------
// tb_alu_arbiter : scoreboard bench for alu_arbiter with a behavioural ALU.
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  localparam int DSIZE = 16;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_BAD = 3'd7;

  typedef struct {
    logic [2:0]       op;
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
    logic [DSIZE-1:0] res;
    logic             zero;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DSIZE(DSIZE)) ifc ();

  alu_arbiter #(.DSIZE(DSIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Behavioural ALU; codes 6 and 7 are undefined and return 0.
  logic [DSIZE-1:0] alu_y;
  always_comb begin
    alu_y = '0;
    case (ifc.alu_op)
      OP_ADD:  alu_y = ifc.alu_a + ifc.alu_b;
      OP_SUB:  alu_y = ifc.alu_a - ifc.alu_b;
      OP_AND:  alu_y = ifc.alu_a & ifc.alu_b;
      OP_OR:   alu_y = ifc.alu_a | ifc.alu_b;
      OP_XOR:  alu_y = ifc.alu_a ^ ifc.alu_b;
      OP_MUL:  alu_y = ifc.alu_a * ifc.alu_b;
      default: alu_y = '0;
    endcase
  end
  assign ifc.alu_out  = alu_y;
  assign ifc.alu_zero = (alu_y == '0);

  op_t stim0[$], stim1[$];
  op_t exp0[$], exp1[$];
  op_t e0, e1;
  int  gnt_log[$];
  int  gnt_cyc[$];
  int  cyc = 0;
  int  run_start = 0;
  int  total = 0;
  int  bad = 0;
  logic prev_g0 = 1'b0;
  logic prev_g1 = 1'b0;
  int  exp_order[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},   32'(ifc.gnt0),   0);
    check({tag, "_gnt1"},   32'(ifc.gnt1),   0);
    check({tag, "_rdy0"},   32'(ifc.rdy0),   0);
    check({tag, "_rdy1"},   32'(ifc.rdy1),   0);
    check({tag, "_busy"},   32'(ifc.busy),   0);
    check({tag, "_res"},    32'(ifc.res),    0);
    check({tag, "_zero"},   32'(ifc.zero),   0);
    check({tag, "_alu_a"},  32'(ifc.alu_a),  0);
    check({tag, "_alu_b"},  32'(ifc.alu_b),  0);
    check({tag, "_alu_op"}, 32'(ifc.alu_op), 0);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: protocol checks plus scoreboard pops on rdy.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_g0 = 1'b0;
      prev_g1 = 1'b0;
    end else begin
      if (ifc.gnt0 || ifc.gnt1) begin
        check("busy_in_gnt", 32'(ifc.busy), 1);
        check("gnt_excl", 32'(ifc.gnt0 & ifc.gnt1), 0);
        gnt_log.push_back(ifc.gnt1 ? 1 : 0);
        gnt_cyc.push_back(cyc);
      end
      if (prev_g0) check("rdy0_after_gnt0", 32'(ifc.rdy0), 1);
      if (prev_g1) check("rdy1_after_gnt1", 32'(ifc.rdy1), 1);
      if (ifc.rdy0 || ifc.rdy1) begin
        check("busy_in_rdy", 32'(ifc.busy), 0);
        check("rdy_excl", 32'(ifc.rdy0 & ifc.rdy1), 0);
      end
      if (ifc.rdy0) begin
        check("rdy0_pending", 32'(exp0.size() != 0), 1);
        if (exp0.size() != 0) begin
          e0 = exp0.pop_front();
          check("res0", 32'(ifc.res), 32'(e0.res));
          check("zero0", 32'(ifc.zero), 32'(e0.zero));
        end
      end
      if (ifc.rdy1) begin
        check("rdy1_pending", 32'(exp1.size() != 0), 1);
        if (exp1.size() != 0) begin
          e1 = exp1.pop_front();
          check("res1", 32'(ifc.res), 32'(e1.res));
          check("zero1", 32'(ifc.zero), 32'(e1.zero));
        end
      end
      prev_g0 = ifc.gnt0;
      prev_g1 = ifc.gnt1;
    end
  end

  task automatic present0(input op_t s);
    ifc.req0 = 1'b1;
    ifc.op0  = s.op;
    ifc.a0   = s.a;
    ifc.b0   = s.b;
    exp0.push_back(s);
  endtask

  task automatic present1(input op_t s);
    ifc.req1 = 1'b1;
    ifc.op1  = s.op;
    ifc.a1   = s.a;
    ifc.b1   = s.b;
    exp1.push_back(s);
  endtask

  // Feeds both stimulus queues; a requester keeps req high through its
  // gnt cycle only when it has a further operation to present.
  task automatic run();
    gnt_log.delete();
    gnt_cyc.delete();
    @(negedge clk);
    run_start = cyc;
    if (stim0.size() != 0) present0(stim0.pop_front());
    if (stim1.size() != 0) present1(stim1.pop_front());
    for (int i = 0; i < 60 && (ifc.req0 || ifc.req1); i++) begin
      @(negedge clk);
      if (ifc.gnt0) begin
        if (stim0.size() != 0) present0(stim0.pop_front());
        else ifc.req0 = 1'b0;
      end
      if (ifc.gnt1) begin
        if (stim1.size() != 0) present1(stim1.pop_front());
        else ifc.req1 = 1'b0;
      end
    end
    check("run_req_timeout", 32'(ifc.req0 | ifc.req1), 0);
    for (int i = 0; i < 10 && (exp0.size() != 0 || exp1.size() != 0); i++)
      @(negedge clk);
    check("drain0", 32'(exp0.size()), 0);
    check("drain1", 32'(exp1.size()), 0);
  endtask

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    ifc.op0  = '0;   ifc.op1  = '0;
    ifc.a0   = '0;   ifc.b0   = '0;
    ifc.a1   = '0;   ifc.b1   = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single ADD from requester 0: grant one cycle after sampling.
    stim0.push_back('{OP_ADD, 16'd5, 16'd7, 16'd12, 1'b0});
    run();
    check("t1_ngnt", gnt_log.size(), 1);
    if (gnt_log.size() >= 1) begin
      check("t1_who", gnt_log[0], 0);
      check("t1_lat", gnt_cyc[0] - run_start, 1);
    end
    check("t1_alu_a_hold", 32'(ifc.alu_a), 5);
    check("t1_alu_b_hold", 32'(ifc.alu_b), 7);

    // SUB to zero from requester 1, then result must hold while idle.
    stim1.push_back('{OP_SUB, 16'd9, 16'd9, 16'd0, 1'b1});
    run();
    check("t2_ngnt", gnt_log.size(), 1);
    if (gnt_log.size() >= 1) check("t2_who", gnt_log[0], 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_res_hold", 32'(ifc.res), 0);
      check("t2_zero_hold", 32'(ifc.zero), 1);
    end

    // Both requesters continuously requesting.
    stim0.push_back('{OP_ADD, 16'd1, 16'd1, 16'd2, 1'b0});
    stim0.push_back('{OP_ADD, 16'd1, 16'd1, 16'd2, 1'b0});
    stim1.push_back('{OP_XOR, 16'd3, 16'd1, 16'd2, 1'b0});
    stim1.push_back('{OP_XOR, 16'd3, 16'd1, 16'd2, 1'b0});
    run();
    check("t3_ngnt", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("t3_order%0d", i), gnt_log[i], exp_order[i]);
      for (int i = 0; i < 3; i++) check($sformatf("t3_gap%0d", i), gnt_cyc[i+1] - gnt_cyc[i], 2);
    end

    // Reset during EXEC discards the operation and restores requester-0 priority.
    @(negedge clk);
    ifc.req0 = 1'b1; ifc.op0 = OP_ADD; ifc.a0 = 16'h11; ifc.b0 = 16'h22;
    for (int i = 0; i < 10 && !ifc.gnt0; i++) @(negedge clk);
    check("t4_gnt0_seen", 32'(ifc.gnt0), 1);
    ifc.req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_no_rdy0", 32'(ifc.rdy0), 0);
    end
    #2 rst_n = 1'b1;
    stim0.push_back('{OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0});
    stim1.push_back('{OP_ADD, 16'd3, 16'd4, 16'd7, 1'b0});
    run();
    check("t4_ngnt", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t4_first", gnt_log[0], 0);
      check("t4_second", gnt_log[1], 1);
    end

    // Truncating multiply and an undefined op code.
    stim0.push_back('{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1});
    run();
    check("t5_ngnt", gnt_log.size(), 1);
    if (gnt_log.size() >= 1) check("t5_lat", gnt_cyc[0] - run_start, 1);
    stim1.push_back('{OP_BAD, 16'h1234, 16'h5678, 16'h0000, 1'b1});
    run();
    check("t5_bad_alu_op", 32'(ifc.alu_op), 32'(OP_BAD));

    // Requester 0 back-to-back with new operands.
    stim0.push_back('{OP_ADD, 16'd2, 16'd3, 16'd5, 1'b0});
    stim0.push_back('{OP_ADD, 16'd4, 16'd4, 16'd8, 1'b0});
    run();
    check("t6_ngnt", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t6_who0", gnt_log[0], 0);
      check("t6_who1", gnt_log[1], 0);
      check("t6_gap", gnt_cyc[1] - gnt_cyc[0], 2);
    end
    check("t6_alu_a_hold", 32'(ifc.alu_a), 4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
